// File: rtl/pref_issue_queue.sv
// pref_issue_queue
//
// Prefetch issue queue placed behind the IP-stride prefetcher. Up to three candidate
// addresses arrive per cycle. Each candidate is aligned to its cache line. A candidate is
// dropped when its line already appears in one of three places: a lower-numbered valid
// slot in the same cycle, the FIFO, or a small filter of recently issued lines. Surviving
// lines enter an in-order FIFO and are issued one per handshake to the memory side.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous active-low reset
//   flush_i          synchronous clear of FIFO and filter; candidates that cycle are discarded
//   pref_addrN_i     candidate N byte address (N=1 highest priority)
//   pref_validN_i    candidate N valid
//   req_addr_o       line-aligned address of the FIFO head
//   req_valid_o      FIFO not empty
//   req_ready_i      memory side accepts the head this cycle
//   occupancy_o      FIFO entry count
//   dup_cnt_o        saturating count of candidates dropped as duplicate/filtered
//   ovf_cnt_o        saturating count of candidates dropped for lack of space

module pref_issue_queue #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned LINE_BITS      = 6,
    parameter int unsigned FILTER_ENTRIES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [63:0]                pref_addr1_i,
    input  logic                       pref_valid1_i,
    input  logic [63:0]                pref_addr2_i,
    input  logic                       pref_valid2_i,
    input  logic [63:0]                pref_addr3_i,
    input  logic                       pref_valid3_i,
    output logic [63:0]                req_addr_o,
    output logic                       req_valid_o,
    input  logic                       req_ready_i,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [15:0]                dup_cnt_o,
    output logic [15:0]                ovf_cnt_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FPTR_W = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;
    localparam logic [63:0] LINE_MASK = (64'd1 << LINE_BITS) - 64'd1;

    // ------------------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------------------
    logic [63:0]               fifo_q [DEPTH];
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;

    logic [63:0]               filt_q [FILTER_ENTRIES];
    logic [FILTER_ENTRIES-1:0] filt_vld_q, filt_vld_d;
    logic [FPTR_W-1:0]         filt_ptr_q, filt_ptr_d;
    logic                      filt_we;

    logic [15:0]               dup_cnt_q, dup_cnt_d;
    logic [15:0]               ovf_cnt_q, ovf_cnt_d;

    // ------------------------------------------------------------------------------------
    // Candidate alignment
    // ------------------------------------------------------------------------------------
    logic [63:0] cand_addr [3];
    logic [63:0] cand_line [3];
    logic [2:0]  cand_vld;

    assign cand_addr[0] = pref_addr1_i;
    assign cand_addr[1] = pref_addr2_i;
    assign cand_addr[2] = pref_addr3_i;

    // Flush discards candidates before they can be counted anywhere.
    assign cand_vld = {pref_valid3_i, pref_valid2_i, pref_valid1_i} & {3{~flush_i}};

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cand_line[k] = cand_addr[k] & ~LINE_MASK;
        end
    end

    // ------------------------------------------------------------------------------------
    // Which FIFO slots currently hold live entries (ring between rd_ptr and count)
    // ------------------------------------------------------------------------------------
    logic [DEPTH-1:0] fifo_vld;

    always_comb begin
        logic [PTR_W-1:0] offs;
        fifo_vld = '0;
        offs     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs        = PTR_W'(i) - rd_ptr_q;
            fifo_vld[i] = ({1'b0, offs} < count_q);
        end
    end

    // ------------------------------------------------------------------------------------
    // Duplicate detection
    // ------------------------------------------------------------------------------------
    logic [2:0] hit_fifo, hit_filt, cand_dup;

    always_comb begin
        hit_fifo = '0;
        hit_filt = '0;
        for (int k = 0; k < 3; k++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (fifo_vld[i] && (fifo_q[i] == cand_line[k])) begin
                    hit_fifo[k] = 1'b1;
                end
            end
            for (int unsigned j = 0; j < FILTER_ENTRIES; j++) begin
                if (filt_vld_q[j] && (filt_q[j] == cand_line[k])) begin
                    hit_filt[k] = 1'b1;
                end
            end
        end
        // Lower-numbered valid slots shadow later ones even if they are themselves dropped.
        cand_dup[0] = hit_fifo[0] | hit_filt[0];
        cand_dup[1] = hit_fifo[1] | hit_filt[1]
                    | (cand_vld[0] && (cand_line[0] == cand_line[1]));
        cand_dup[2] = hit_fifo[2] | hit_filt[2]
                    | (cand_vld[0] && (cand_line[0] == cand_line[2]))
                    | (cand_vld[1] && (cand_line[1] == cand_line[2]));
    end

    // ------------------------------------------------------------------------------------
    // Enqueue allocation: survivors in slot order, limited by start-of-cycle free space
    // ------------------------------------------------------------------------------------
    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] n_enq;
    logic [1:0]       n_dup, n_ovf;
    logic [2:0]       enq_en;
    logic [PTR_W-1:0] enq_idx [3];

    always_comb begin
        free_slots = CNT_W'(DEPTH) - count_q;
        n_enq      = '0;
        n_dup      = '0;
        n_ovf      = '0;
        enq_en     = '0;
        for (int k = 0; k < 3; k++) begin
            enq_idx[k] = wr_ptr_q + n_enq[PTR_W-1:0];
            if (cand_vld[k]) begin
                if (cand_dup[k]) begin
                    n_dup = n_dup + 2'd1;
                end else if (n_enq < free_slots) begin
                    enq_en[k] = 1'b1;
                    n_enq     = n_enq + CNT_W'(1);
                end else begin
                    n_ovf = n_ovf + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // Pointer, count, filter and counter next state
    // ------------------------------------------------------------------------------------
    logic        deq;
    logic [16:0] dup_sum, ovf_sum;

    assign deq = (count_q != '0) && req_ready_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        wr_ptr_d = wr_ptr_q + n_enq[PTR_W-1:0];
        count_d  = count_q + n_enq - CNT_W'(deq);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        filt_we    = 1'b0;
        filt_vld_d = filt_vld_q;
        filt_ptr_d = filt_ptr_q;
        if (flush_i) begin
            // An issue completing during flush is not remembered.
            filt_vld_d = '0;
            filt_ptr_d = '0;
        end else if (deq) begin
            filt_we                = 1'b1;
            filt_vld_d[filt_ptr_q] = 1'b1;
            filt_ptr_d = (filt_ptr_q == FPTR_W'(FILTER_ENTRIES - 1)) ? '0
                                                                     : filt_ptr_q + FPTR_W'(1);
        end
    end

    always_comb begin
        dup_sum   = {1'b0, dup_cnt_q} + 17'(n_dup);
        ovf_sum   = {1'b0, ovf_cnt_q} + 17'(n_ovf);
        dup_cnt_d = dup_sum[16] ? 16'hFFFF : dup_sum[15:0];
        ovf_cnt_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end

    // ------------------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            filt_vld_q <= '0;
            filt_ptr_q <= '0;
            dup_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            filt_vld_q <= filt_vld_d;
            filt_ptr_q <= filt_ptr_d;
            dup_cnt_q  <= dup_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Payload storage needs no reset; liveness comes from count_q and filt_vld_q.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (enq_en[k]) begin
                fifo_q[enq_idx[k]] <= cand_line[k];
            end
        end
        if (filt_we) begin
            filt_q[filt_ptr_q] <= fifo_q[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------------------
    assign req_valid_o = (count_q != '0);
    assign req_addr_o  = req_valid_o ? fifo_q[rd_ptr_q] : '0;
    assign occupancy_o = count_q;
    assign dup_cnt_o   = dup_cnt_q;
    assign ovf_cnt_o   = ovf_cnt_q;

endmodule

// File: tb/tb_pref_issue_queue.sv
module tb_pref_issue_queue;

    localparam int DEPTH = 8;
    localparam int FE    = 16;
    localparam logic [63:0] LMASK = 64'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [63:0] pref_addr1_i = '0, pref_addr2_i = '0, pref_addr3_i = '0;
    logic        pref_valid1_i = 1'b0, pref_valid2_i = 1'b0, pref_valid3_i = 1'b0;
    logic [63:0] req_addr_o;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic [3:0]  occupancy_o;
    logic [15:0] dup_cnt_o, ovf_cnt_o;

    always #5 clk = ~clk;

    pref_issue_queue #(.DEPTH(DEPTH), .LINE_BITS(6), .FILTER_ENTRIES(FE)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .pref_addr1_i (pref_addr1_i),
        .pref_valid1_i(pref_valid1_i),
        .pref_addr2_i (pref_addr2_i),
        .pref_valid2_i(pref_valid2_i),
        .pref_addr3_i (pref_addr3_i),
        .pref_valid3_i(pref_valid3_i),
        .req_addr_o   (req_addr_o),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .occupancy_o  (occupancy_o),
        .dup_cnt_o    (dup_cnt_o),
        .ovf_cnt_o    (ovf_cnt_o)
    );

    // Reference model: queue of pending lines, queue of remembered issued lines.
    logic [63:0] m_q[$];
    logic [63:0] m_f[$];
    int          m_dup = 0;
    int          m_ovf = 0;
    bit          cmp_en = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_q(input logic [63:0] q[$], input logic [63:0] x);
        foreach (q[i]) if (q[i] == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat16(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    // Drive one cycle of inputs and advance the model across the rising edge.
    task automatic step(input bit fl, input bit v1, input logic [63:0] a1,
                        input bit v2, input logic [63:0] a2,
                        input bit v3, input logic [63:0] a3, input bit rdy);
        logic [63:0] nq[$];
        logic [63:0] nf[$];
        logic [63:0] seen[$];
        logic [63:0] a[3];
        logic [63:0] l;
        bit          v[3];
        bit          deq, dup;
        int          nd, no, free, enq;
        @(negedge clk);
        flush_i = fl; req_ready_i = rdy;
        pref_valid1_i = v1; pref_addr1_i = a1;
        pref_valid2_i = v2; pref_addr2_i = a2;
        pref_valid3_i = v3; pref_addr3_i = a3;
        v[0] = v1; v[1] = v2; v[2] = v3;
        a[0] = a1; a[1] = a2; a[2] = a3;
        nq = m_q; nf = m_f; nd = 0; no = 0; enq = 0;
        deq = (m_q.size() != 0) && rdy;
        if (fl) begin
            nq.delete();
            nf.delete();
        end else begin
            free = DEPTH - m_q.size();
            if (deq) begin
                nf.push_back(nq.pop_front());
                if (nf.size() > FE) void'(nf.pop_front());
            end
            for (int k = 0; k < 3; k++) begin
                if (v[k]) begin
                    l   = a[k] & ~LMASK;
                    dup = in_q(seen, l) || in_q(m_q, l) || in_q(m_f, l);
                    seen.push_back(l);
                    if (dup) nd++;
                    else if (enq < free) begin nq.push_back(l); enq++; end
                    else no++;
                end
            end
        end
        @(posedge clk);
        m_q = nq; m_f = nf;
        m_dup = sat16(m_dup + nd);
        m_ovf = sat16(m_ovf + no);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        flush_i = 1'b0; req_ready_i = 1'b0;
        pref_valid1_i = 1'b0; pref_valid2_i = 1'b0; pref_valid3_i = 1'b0;
        m_q.delete(); m_f.delete(); m_dup = 0; m_ovf = 0;
        #1;
        chk("rst_valid", req_valid_o, 0);
        chk("rst_addr", req_addr_o, 0);
        chk("rst_occ", occupancy_o, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst && cmp_en) begin
            chk("req_valid", req_valid_o, m_q.size() != 0);
            if (m_q.size() != 0) chk("req_addr", req_addr_o, m_q[0]);
            chk("occupancy", occupancy_o, m_q.size());
            chk("dup_cnt", dup_cnt_o, m_dup);
            chk("ovf_cnt", ovf_cnt_o, m_ovf);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] a[3];
        bit          v[3];
        cmp_en = 1'b1;

        // 1: latency and filter hit after issue
        do_reset();
        step(0, 1, 64'h1000, 0, '0, 0, '0, 1);
        #1; chk("t1_valid", req_valid_o, 1); chk("t1_addr", req_addr_o, 64'h1000);
        idle(1);
        idle(1);
        step(0, 1, 64'h1010, 0, '0, 0, '0, 1);
        #1; chk("t1_dup", dup_cnt_o, 1); chk("t1_empty", req_valid_o, 0);

        // 2: same-cycle duplicate
        do_reset();
        step(0, 1, 64'h40, 1, 64'h48, 1, 64'h80, 0);
        #1; chk("t2_occ", occupancy_o, 2); chk("t2_head", req_addr_o, 64'h40);
        chk("t2_dup", dup_cnt_o, 1);
        step(0, 0, '0, 0, '0, 0, '0, 1);
        #1; chk("t2_second", req_addr_o, 64'h80);

        // 3: overflow with no same-cycle space credit
        do_reset();
        step(0, 1, 64'h1000, 1, 64'h2000, 1, 64'h3000, 0);
        step(0, 1, 64'h4000, 1, 64'h5000, 1, 64'h6000, 0);
        step(0, 1, 64'h7000, 1, 64'h8000, 1, 64'h9000, 0);
        #1; chk("t3_occ", occupancy_o, 8); chk("t3_ovf", ovf_cnt_o, 1);
        chk("t3_head", req_addr_o, 64'h1000);

        // 4: toggling ready drains in order, address stable while stalled
        for (int k = 0; k < 8; k++) begin
            idle(0);
            #1; chk("t4_hold", req_addr_o, 64'h1000 * (k + 1));
            idle(1);
            #1;
            if (k < 7) chk("t4_next", req_addr_o, 64'h1000 * (k + 2));
            else       chk("t4_drained", req_valid_o, 0);
        end

        // 5: filter eviction after 17 issues
        do_reset();
        for (int k = 1; k <= 17; k++) step(0, 1, 64'(k) << 12, 0, '0, 0, '0, 1);
        idle(1);
        step(0, 1, 64'h1008, 0, '0, 0, '0, 1);
        #1; chk("t5_readmit", req_addr_o, 64'h1000); chk("t5_nodup", dup_cnt_o, 0);
        step(0, 1, 64'h11000, 0, '0, 0, '0, 1);
        #1; chk("t5_filtered", dup_cnt_o, 1); chk("t5_empty", req_valid_o, 0);

        // 6: asynchronous reset mid-cycle
        do_reset();
        step(0, 1, 64'h100, 1, 64'h140, 1, 64'h180, 0);
        step(0, 1, 64'h1C0, 1, 64'h200, 1, 64'h100, 0);
        #1; chk("t6_occ", occupancy_o, 5); chk("t6_dup", dup_cnt_o, 1);
        #1;
        rst = 1'b0;
        m_q.delete(); m_f.delete(); m_dup = 0; m_ovf = 0;
        #1;
        chk("t6_valid", req_valid_o, 0); chk("t6_occ0", occupancy_o, 0);
        chk("t6_dup0", dup_cnt_o, 0); chk("t6_ovf0", ovf_cnt_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // 7: flush with a completing handshake and a candidate
        do_reset();
        step(0, 1, 64'h3000, 1, 64'h3040, 1, 64'h3000, 0);
        step(0, 1, 64'h3080, 1, 64'h30C0, 0, '0, 0);
        #1; chk("t7_occ4", occupancy_o, 4);
        step(1, 1, 64'h5000, 0, '0, 0, '0, 1);
        #1; chk("t7_occ0", occupancy_o, 0); chk("t7_valid", req_valid_o, 0);
        chk("t7_dup", dup_cnt_o, 1); chk("t7_ovf", ovf_cnt_o, 0);
        step(0, 1, 64'h3000, 0, '0, 0, '0, 0);
        #1; chk("t7_notfilt", occupancy_o, 1); chk("t7_dup_same", dup_cnt_o, 1);

        // Randomized traffic over a small line pool to provoke all drop paths
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 3; k++) begin
                v[k] = ($urandom_range(0, 9) < 6);
                a[k] = (64'($urandom_range(0, 27)) << 6) | 64'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) a[k] = a[k] | 64'hA5A5_0000_0000_0000;
            end
            step($urandom_range(0, 49) == 0, v[0], a[0], v[1], a[1], v[2], a[2],
                 $urandom_range(0, 1) == 1);
        end
        idle(0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
